cache_mem_bridge: RTL and testbench
===================================

# cache_mem_bridge

Memory-side line-transfer engine between `cache_controller` and main memory. It converts the controller's one-shot `read_en_mem` / `write_en_mem` strobes into word-by-word bus transactions: optional write-back of a dirty victim line, then a refill fetch. On refill completion it pulses `ready_mem` back to the controller and presents the assembled line for the cache data array write.

## Interface
- `ADDR_W`, 32, byte-address width.
- `WORD_W`, 32, memory bus data width; must be a multiple of 8.
- `WORDS_PER_LINE`, 4, beats per cache line; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `read_en_mem` input 1: clean-miss strobe from controller; start refill.
- `write_en_mem` input 1: dirty-miss strobe from controller; start write-back, then refill.
- `miss_addr` input ADDR_W: byte address of the missing access; sampled at accept.
- `wb_addr` input ADDR_W: base byte address of the victim line; sampled at accept.
- `wb_line` input WORD_W*WORDS_PER_LINE: victim line data; sampled at accept.
- `ready_mem` output 1: one-cycle pulse, refill line valid.
- `refill_line` output WORD_W*WORDS_PER_LINE: fetched line; word i at `[i*WORD_W +: WORD_W]`.
- `busy` output 1: high in every state except IDLE.
- `mem_req_valid` output 1; `mem_req_we` output 1; `mem_req_addr` output ADDR_W; `mem_req_wdata` output WORD_W: request channel.
- `mem_req_ready` input 1: memory accepts request when high with `mem_req_valid`.
- `mem_rsp_valid` input 1; `mem_rsp_rdata` input WORD_W: read response channel.

## Operation
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, DONE.
- IDLE: `write_en_mem`=1 → latch `wb_addr`, `wb_line`, `miss_addr`; beat=0; → WB_REQ. Otherwise `read_en_mem`=1 → latch `miss_addr`; beat=0; → RD_REQ. Both high: write path wins; the refill still follows.
- Strobes are ignored outside IDLE. The controller's second `write_en_mem` cycle arrives while busy, so it does not restart.
- Line base = address with low log2(WORDS_PER_LINE)+log2(WORD_W/8) bits forced to 0. Beat address = line base + beat*(WORD_W/8).
- WB_REQ: `mem_req_valid`=1, `we`=1, `wdata`=victim word[beat].
  - Beat completes on `valid&&ready`.
  - Last beat → beat=0, RD_REQ. Otherwise beat+1.
  - No write response is expected.
- RD_REQ: `mem_req_valid`=1, `we`=0, address of beat. Handshake → RD_WAIT.
- RD_WAIT: on `mem_rsp_valid`, store `rdata` into `refill_line` word[beat].
  - Last beat → DONE. Otherwise beat+1, → RD_REQ.
  - One outstanding read at a time.
- DONE: `ready_mem`=1 for exactly one cycle, → IDLE. `refill_line` holds until the next refill overwrites its words.
- `mem_rsp_valid` outside RD_WAIT is a protocol error and is ignored.
- Request signals stay stable while `valid`=1 and `ready`=0.
- Beat counter width is log2(WORDS_PER_LINE) and wraps naturally after the last beat.

## Timing
- Reset: state IDLE, beat 0, `refill_line` 0. All outputs 0: `ready_mem`, `busy`, `mem_req_valid`, `mem_req_we`, `mem_req_addr`, `mem_req_wdata`.
- Reset mid-transfer: the next cycle is IDLE with `mem_req_valid`=0; partial line data is discarded.
- Outputs decode from registered state and latched data; no combinational path from `mem_*` inputs to `mem_req_*`.
- Zero-wait memory means `ready` high and `rsp_valid` the cycle after handshake. Strobe sampled at edge 0.
  - Clean miss: `ready_mem` high in cycle 1+2*WORDS_PER_LINE (9 for default).
  - Dirty miss: cycle 1+3*WORDS_PER_LINE (13 for default).
- Minimum latency is ≥5 cycles, so `ready_mem` always lands while the controller sits in WRITE_ALLOCATE.

## Structure
- Shared `cache_pkg`: `bridge_state_t` enum and default width parameters. Add the localparams OFFSET_W and BEAT_W there, or derive them locally via `$clog2`.
- Single module; no sub-module. The line buffer is an internal register array indexed by beat.

## Test plan
- Clean miss: `miss_addr`=0x0000_1234, zero-wait memory returning addr^0xA5A5_0000.
  - Expect read addresses 0x1230, 0x1234, 0x1238, 0x123C.
  - Expect `ready_mem` pulse at cycle 9 and `refill_line` word2 = 0xA5A5_1238.
- Dirty miss: `wb_addr`=0x0000_8000, `wb_line`={4,3,2,1}, `miss_addr`=0x40.
  - Expect writes (0x8000,1), (0x8004,2), (0x8008,3), (0x800C,4).
  - Then reads 0x40–0x4C, then `ready_mem` at cycle 13.
- Backpressure: `mem_req_ready` low for 3 cycles on beat 1 → address and data held constant; only one beat issued.
- Strobe while busy: `read_en_mem` pulsed in RD_WAIT → ignored; exactly 4 reads and one `ready_mem` pulse.
- Simultaneous `read_en_mem`=`write_en_mem`=1 in IDLE → write-back first, then refill.
- `rst` asserted in RD_WAIT of beat 2 → next cycle IDLE, `busy`=0, `mem_req_valid`=0, `ready_mem` never pulses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache types: bridge FSM state encoding and default geometry.
package cache_pkg;

    localparam int ADDR_W_DEFAULT         = 32;
    localparam int WORD_W_DEFAULT         = 32;
    localparam int WORDS_PER_LINE_DEFAULT = 4;

    // Geometry derived from the defaults; modules re-derive from their own parameters.
    localparam int DEF_BEAT_W   = $clog2(WORDS_PER_LINE_DEFAULT);
    localparam int DEF_OFFSET_W = DEF_BEAT_W + $clog2(WORD_W_DEFAULT / 8);

    typedef enum logic [2:0] {
        BR_IDLE    = 3'd0,
        BR_WB_REQ  = 3'd1,
        BR_RD_REQ  = 3'd2,
        BR_RD_WAIT = 3'd3,
        BR_DONE    = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/cache_mem_bridge.sv
// Memory-side line-transfer engine: optional dirty-victim write-back followed
// by a word-by-word refill, then a one-cycle ready_mem pulse to the controller.
//
// Request channel handshake: a beat transfers on a rising edge where
// mem_req_valid && mem_req_ready. While valid is high and ready is low, the
// request fields (we/addr/wdata) are held stable because they decode only from
// registered state, beat counter and latched data. Read data returns on
// mem_rsp_valid (no ready back-pressure) and is only accepted in RD_WAIT; a
// response at any other time is dropped. Only one read is ever outstanding.
module cache_mem_bridge
    import cache_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int WORD_W         = WORD_W_DEFAULT,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             read_en_mem,
    input  logic                             write_en_mem,
    input  logic [ADDR_W-1:0]                miss_addr,
    input  logic [ADDR_W-1:0]                wb_addr,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] wb_line,
    output logic                             ready_mem,
    output logic [WORD_W*WORDS_PER_LINE-1:0] refill_line,
    output logic                             busy,
    output logic                             mem_req_valid,
    output logic                             mem_req_we,
    output logic [ADDR_W-1:0]                mem_req_addr,
    output logic [WORD_W-1:0]                mem_req_wdata,
    input  logic                             mem_req_ready,
    input  logic                             mem_rsp_valid,
    input  logic [WORD_W-1:0]                mem_rsp_rdata,
    output logic [2:0]                       dbg_state
);

    localparam int BYTES_PER_WORD = WORD_W / 8;
    localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
    localparam int BYTE_OFF_W     = $clog2(BYTES_PER_WORD);
    localparam int OFFSET_W       = BEAT_W + BYTE_OFF_W;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(WORDS_PER_LINE - 1);

    bridge_state_t     state;
    bridge_state_t     next_state;
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] wb_base;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] beat_off;
    logic [WORD_W-1:0] victim [WORDS_PER_LINE];
    logic [WORD_W-1:0] refill [WORDS_PER_LINE];
    logic              last_beat;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

    assign last_beat = (beat == LAST_BEAT);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BR_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; write-back takes priority and always chains into refill.
    always_comb begin
        next_state = state;
        case (state)
            BR_IDLE: begin
                if (write_en_mem) begin
                    next_state = BR_WB_REQ;
                end else if (read_en_mem) begin
                    next_state = BR_RD_REQ;
                end
            end
            BR_WB_REQ: begin
                if (mem_req_ready && last_beat) begin
                    next_state = BR_RD_REQ;
                end
            end
            BR_RD_REQ: begin
                if (mem_req_ready) begin
                    next_state = BR_RD_WAIT;
                end
            end
            BR_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    next_state = last_beat ? BR_DONE : BR_RD_REQ;
                end
            end
            BR_DONE: next_state = BR_IDLE;
            default: next_state = BR_IDLE;
        endcase
    end

    // Request fields and status decode from registered state and latched data only.
    always_comb begin
        ready_mem     = 1'b0;
        busy          = (state != BR_IDLE);
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        beat_off      = ADDR_W'(beat) << BYTE_OFF_W;
        case (state)
            BR_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = wb_base | beat_off;
                mem_req_wdata = victim[beat];
            end
            BR_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = rd_base | beat_off;
            end
            BR_DONE: ready_mem = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch addresses/victim at accept, step the beat counter, fill the line buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat    <= '0;
            wb_base <= '0;
            rd_base <= '0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                victim[i] <= '0;
                refill[i] <= '0;
            end
        end else begin
            case (state)
                BR_IDLE: begin
                    if (write_en_mem) begin
                        wb_base <= line_base(wb_addr);
                        rd_base <= line_base(miss_addr);
                        beat    <= '0;
                        for (int i = 0; i < WORDS_PER_LINE; i++) begin
                            victim[i] <= wb_line[i*WORD_W +: WORD_W];
                        end
                    end else if (read_en_mem) begin
                        rd_base <= line_base(miss_addr);
                        beat    <= '0;
                    end
                end
                BR_WB_REQ: begin
                    // Wraps to 0 after the last beat, ready for the refill.
                    if (mem_req_ready) begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                BR_RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        refill[beat] <= mem_rsp_rdata;
                        beat         <= beat + BEAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten the line buffer: word i at [i*WORD_W +: WORD_W].
    always_comb begin
        refill_line = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            refill_line[i*WORD_W +: WORD_W] = refill[i];
        end
    end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: zero-wait memory model with optional
// single-address stall, one task per scenario, inline checks.
module tb_cache_mem_bridge;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int WPL    = 4;
    localparam int LINE_W = WORD_W * WPL;

    logic              clk;
    logic              rst;
    logic              read_en_mem;
    logic              write_en_mem;
    logic [ADDR_W-1:0] miss_addr;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_line;
    logic              ready_mem;
    logic [LINE_W-1:0] refill_line;
    logic              busy;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [WORD_W-1:0] mem_req_wdata;
    logic              mem_req_ready = 1'b0;
    logic              mem_rsp_valid = 1'b0;
    logic [WORD_W-1:0] mem_rsp_rdata = '0;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    cache_mem_bridge #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W),
        .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .read_en_mem(read_en_mem),
        .write_en_mem(write_en_mem),
        .miss_addr(miss_addr),
        .wb_addr(wb_addr),
        .wb_line(wb_line),
        .ready_mem(ready_mem),
        .refill_line(refill_line),
        .busy(busy),
        .mem_req_valid(mem_req_valid),
        .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .dbg_state(dbg_state)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Memory model: accepted requests are logged; reads answer in the next cycle
    // with addr ^ 0xA5A5_0000. One address/direction can be stalled N cycles.
    logic [ADDR_W-1:0] log_addr  [$];
    logic              log_we    [$];
    logic [WORD_W-1:0] log_wdata [$];
    logic [ADDR_W-1:0] stall_addr_log  [$];
    logic [WORD_W-1:0] stall_wdata_log [$];
    logic [ADDR_W-1:0] stall_addr = '1;
    logic              stall_we   = 1'b0;
    int                stall_used  = 0;
    int                stall_total = 0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;

    always @(negedge clk) begin
        mem_rsp_valid = pend;
        mem_rsp_rdata = pend ? (pend_addr ^ 32'hA5A5_0000) : '0;
        pend = 1'b0;
        if (mem_req_valid && mem_req_addr == stall_addr && mem_req_we == stall_we
            && stall_used < stall_total) begin
            mem_req_ready = 1'b0;
            stall_used++;
            stall_addr_log.push_back(mem_req_addr);
            stall_wdata_log.push_back(mem_req_wdata);
        end else begin
            mem_req_ready = 1'b1;
            if (mem_req_valid) begin
                log_addr.push_back(mem_req_addr);
                log_we.push_back(mem_req_we);
                log_wdata.push_back(mem_req_wdata);
                if (!mem_req_we) begin
                    pend      = 1'b1;
                    pend_addr = mem_req_addr;
                end
            end
        end
    end

    task automatic clear_logs();
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
        stall_addr_log.delete();
        stall_wdata_log.delete();
    endtask

    // Driver: strobe sampled at edge 0; cycle c is the interval after edge c-1.
    task automatic run_op(input logic we, input logic re, input logic [ADDR_W-1:0] maddr,
                          input logic [ADDR_W-1:0] waddr, input logic [LINE_W-1:0] line,
                          input int poke_cyc, input int budget,
                          output int first_rdy, output int n_rdy);
        @(negedge clk);
        miss_addr    = maddr;
        wb_addr      = waddr;
        wb_line      = line;
        write_en_mem = we;
        read_en_mem  = re;
        @(negedge clk);
        write_en_mem = 1'b0;
        read_en_mem  = 1'b0;
        first_rdy = -1;
        n_rdy     = 0;
        for (int c = 1; c <= budget; c++) begin
            if (ready_mem) begin
                if (first_rdy < 0) first_rdy = c;
                n_rdy++;
            end
            read_en_mem = (c == poke_cyc);
            @(negedge clk);
        end
        read_en_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        read_en_mem  = 1'b0;
        write_en_mem = 1'b0;
        miss_addr    = '0;
        wb_addr      = '0;
        wb_line      = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ready_mem !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b rdy=%b valid=%b we=%b required all 0",
                     busy, ready_mem, mem_req_valid, mem_req_we);
        end
        n_checks++;
        if (mem_req_addr !== '0 || mem_req_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_req: got addr=%h wdata=%h required 0", mem_req_addr, mem_req_wdata);
        end
        n_checks++;
        if (refill_line !== '0) begin
            n_fail++;
            $display("FAIL reset_line: got %h required 0", refill_line);
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required 0", dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_miss();
        int fr, nr;
        logic [WORD_W-1:0] exp;
        clear_logs();
        run_op(1'b0, 1'b1, 32'h0000_1234, 32'h0, '0, 0, 24, fr, nr);
        n_checks++;
        if (log_addr.size() != 4) begin
            n_fail++;
            $display("FAIL clean_count: got %0d requests required 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_addr[i] !== 32'h1230 + 32'(4*i) || log_we[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clean_rd%0d: got addr=%h we=%b required addr=%h we=0",
                             i, log_addr[i], log_we[i], 32'h1230 + 32'(4*i));
                end
            end
        end
        n_checks++;
        if (fr != 9 || nr != 1) begin
            n_fail++;
            $display("FAIL clean_ready: got cycle=%0d pulses=%0d required cycle=9 pulses=1", fr, nr);
        end
        n_checks++;
        if (refill_line[2*WORD_W +: WORD_W] !== 32'hA5A5_1238) begin
            n_fail++;
            $display("FAIL clean_word2: got %h required a5a51238", refill_line[2*WORD_W +: WORD_W]);
        end
        for (int i = 0; i < 4; i++) begin
            exp = (32'h1230 + 32'(4*i)) ^ 32'hA5A5_0000;
            n_checks++;
            if (refill_line[i*WORD_W +: WORD_W] !== exp) begin
                n_fail++;
                $display("FAIL clean_line%0d: got %h required %h", i, refill_line[i*WORD_W +: WORD_W], exp);
            end
        end
    endtask

    task automatic test_dirty_miss(input logic both);
        int fr, nr;
        logic [LINE_W-1:0] line;
        logic [WORD_W-1:0] exp;
        line = {32'd4, 32'd3, 32'd2, 32'd1};
        clear_logs();
        run_op(1'b1, both, 32'h0000_0040, 32'h0000_8000, line, 0, 24, fr, nr);
        n_checks++;
        if (log_addr.size() != 8) begin
            n_fail++;
            $display("FAIL dirty_count(both=%b): got %0d requests required 8", both, log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_addr[i] !== 32'h8000 + 32'(4*i) || log_we[i] !== 1'b1 || log_wdata[i] !== 32'(i+1)) begin
                    n_fail++;
                    $display("FAIL dirty_wr%0d: got addr=%h we=%b data=%h required addr=%h we=1 data=%h",
                             i, log_addr[i], log_we[i], log_wdata[i], 32'h8000 + 32'(4*i), 32'(i+1));
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_addr[i+4] !== 32'h40 + 32'(4*i) || log_we[i+4] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dirty_rd%0d: got addr=%h we=%b required addr=%h we=0",
                             i, log_addr[i+4], log_we[i+4], 32'h40 + 32'(4*i));
                end
            end
        end
        n_checks++;
        if (fr != 13 || nr != 1) begin
            n_fail++;
            $display("FAIL dirty_ready: got cycle=%0d pulses=%0d required cycle=13 pulses=1", fr, nr);
        end
        for (int i = 0; i < 4; i++) begin
            exp = (32'h40 + 32'(4*i)) ^ 32'hA5A5_0000;
            n_checks++;
            if (refill_line[i*WORD_W +: WORD_W] !== exp) begin
                n_fail++;
                $display("FAIL dirty_line%0d: got %h required %h", i, refill_line[i*WORD_W +: WORD_W], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int fr, nr, hits;
        clear_logs();
        stall_addr  = 32'h9004;
        stall_we    = 1'b1;
        stall_total = stall_used + 3;
        run_op(1'b1, 1'b0, 32'h0000_0300, 32'h0000_9000,
               {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A}, 0, 28, fr, nr);
        n_checks++;
        if (stall_addr_log.size() != 3) begin
            n_fail++;
            $display("FAIL bp_stalls: got %0d stalled cycles required 3", stall_addr_log.size());
        end
        foreach (stall_addr_log[i]) begin
            n_checks++;
            if (stall_addr_log[i] !== 32'h9004 || stall_wdata_log[i] !== 32'h0000_000B) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got addr=%h data=%h required addr=00009004 data=0000000b",
                         i, stall_addr_log[i], stall_wdata_log[i]);
            end
        end
        hits = 0;
        foreach (log_addr[i]) if (log_addr[i] == 32'h9004) hits++;
        n_checks++;
        if (hits != 1 || log_addr.size() != 8) begin
            n_fail++;
            $display("FAIL bp_issue: got beat1 issues=%0d total=%0d required 1 and 8", hits, log_addr.size());
        end
        n_checks++;
        if (fr != 16 || nr != 1) begin
            n_fail++;
            $display("FAIL bp_ready: got cycle=%0d pulses=%0d required cycle=16 pulses=1", fr, nr);
        end
        stall_addr = '1;
    endtask

    task automatic test_strobe_while_busy();
        int fr, nr;
        clear_logs();
        run_op(1'b0, 1'b1, 32'h0000_0500, 32'h0, '0, 2, 24, fr, nr);
        n_checks++;
        if (log_addr.size() != 4) begin
            n_fail++;
            $display("FAIL busy_reads: got %0d requests required 4", log_addr.size());
        end
        n_checks++;
        if (fr != 9 || nr != 1) begin
            n_fail++;
            $display("FAIL busy_ready: got cycle=%0d pulses=%0d required cycle=9 pulses=1", fr, nr);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int nr;
        clear_logs();
        @(negedge clk);
        miss_addr   = 32'h0000_0700;
        read_en_mem = 1'b1;
        @(negedge clk);
        read_en_mem = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (dbg_state !== 3'd3) begin
            n_fail++;
            $display("FAIL rstmid_wait: got state=%0d required 3", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || ready_mem !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got busy=%b valid=%b rdy=%b required 0 0 0",
                     busy, mem_req_valid, ready_mem);
        end
        nr = 0;
        for (int c = 0; c < 20; c++) begin
            if (ready_mem) nr++;
            @(negedge clk);
        end
        n_checks++;
        if (nr != 0 || log_addr.size() != 3) begin
            n_fail++;
            $display("FAIL rstmid_after: got pulses=%0d reads=%0d required 0 and 3", nr, log_addr.size());
        end
        n_checks++;
        if (refill_line !== '0) begin
            n_fail++;
            $display("FAIL rstmid_line: got %h required 0", refill_line);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss(1'b0);
        test_backpressure();
        test_strobe_while_busy();
        test_dirty_miss(1'b1);
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
